// File: rtl/dnn2ami_pkg.sv
// Shared constants and types for the DNN2AMI write sequencer.
package dnn2ami_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int unsigned BEAT_BYTES_DEF = 64;
  localparam int unsigned AMI_ADDR_W     = 64;
  localparam int unsigned AMI_DATA_W     = 512;

  typedef struct packed {
    logic [AMI_ADDR_W-1:0] addr;
    logic [AMI_DATA_W-1:0] data;
  } ami_req_t;

endpackage

// File: rtl/dnn2ami_credit_counter.sv
// Outstanding AMI write tracker: up on issue, down on response, flags
// responses that arrive with nothing outstanding.
module dnn2ami_credit_counter #(
  parameter int MAX_OUTSTANDING = 8,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic has_credit,
  output logic empty,
  output logic resp_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] count;
  logic             dec_ok;

  assign empty      = (count == '0);
  assign has_credit = (count < MAX_CNT);
  // An unmatched response is recorded but never lets the counter underflow.
  assign dec_ok     = dec && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      resp_err <= 1'b0;
    end else begin
      if (dec && empty) begin
        resp_err <= 1'b1;
      end
      case ({inc, dec_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dnn2ami_wr_sequencer.sv
// Fractures one macro write into single-beat AMI writes, pulling beat data
// round-robin from the PU output buffers and waiting for every ack.
module dnn2ami_wr_sequencer
  import dnn2ami_pkg::*;
#(
  parameter int NUM_PU          = 2,
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 64,
  parameter int SIZE_WIDTH      = 10,
  parameter int BEAT_BYTES      = BEAT_BYTES_DEF,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         macro_valid,
  output logic                         macro_ready,
  input  logic [ADDR_WIDTH-1:0]        macro_addr,
  input  logic [SIZE_WIDTH-1:0]        macro_size,
  input  logic [NUM_PU-1:0]            outbuf_valid,
  input  logic [NUM_PU*DATA_WIDTH-1:0] outbuf_data,
  output logic [NUM_PU-1:0]            outbuf_pop,
  output logic                         ami_wr_valid,
  input  logic                         ami_wr_ready,
  output logic [ADDR_WIDTH-1:0]        ami_wr_addr,
  output logic [DATA_WIDTH-1:0]        ami_wr_data,
  input  logic                         ami_wr_resp,
  output logic                         busy,
  output logic                         done,
  output logic                         resp_err
);

  localparam int PU_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

  logic [1:0]            state;
  logic [SIZE_WIDTH-1:0] beats_left;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [PU_W-1:0]       pu_sel;
  logic                  has_credit;
  logic                  cnt_zero;
  logic                  issue_hs;

  dnn2ami_credit_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk       (clk),
    .rst       (rst),
    .inc       (issue_hs),
    .dec       (ami_wr_resp),
    .has_credit(has_credit),
    .empty     (cnt_zero),
    .resp_err  (resp_err)
  );

  assign macro_ready  = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign ami_wr_valid = (state == ST_ISSUE) && outbuf_valid[pu_sel] && has_credit;
  assign ami_wr_addr  = cur_addr;
  assign ami_wr_data  = outbuf_data[pu_sel*DATA_WIDTH +: DATA_WIDTH];
  assign issue_hs     = ami_wr_valid && ami_wr_ready;
  // Combinational so a zero-length request completes the cycle after acceptance.
  assign done         = (state == ST_DRAIN) && cnt_zero;

  always_comb begin
    outbuf_pop = '0;
    if (issue_hs) begin
      outbuf_pop[pu_sel] = 1'b1;
    end else begin
      outbuf_pop = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      beats_left <= '0;
      cur_addr   <= '0;
      pu_sel     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (macro_valid) begin
            cur_addr   <= macro_addr;
            beats_left <= macro_size;
            pu_sel     <= '0;
            state      <= (macro_size != '0) ? ST_ISSUE : ST_DRAIN;
          end
        end
        ST_ISSUE: begin
          if (issue_hs) begin
            cur_addr   <= cur_addr + ADDR_WIDTH'(BEAT_BYTES);
            beats_left <= beats_left - SIZE_WIDTH'(1);
            pu_sel     <= (pu_sel == PU_W'(NUM_PU - 1)) ? '0 : pu_sel + PU_W'(1);
            if (beats_left == SIZE_WIDTH'(1)) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (cnt_zero) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dnn2ami_wr_sequencer.sv
// Scoreboard bench: expected beats are queued when a macro is driven and
// matched against each AMI issue handshake.
module tb_dnn2ami_wr_sequencer;

  localparam int NUM_PU = 2;
  localparam int DW     = 512;
  localparam int AW     = 64;
  localparam int SW     = 10;
  localparam int MAXO   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 macro_valid;
  logic                 macro_ready;
  logic [AW-1:0]        macro_addr;
  logic [SW-1:0]        macro_size;
  logic [NUM_PU-1:0]    outbuf_valid;
  logic [NUM_PU*DW-1:0] outbuf_data;
  logic [NUM_PU-1:0]    outbuf_pop;
  logic                 ami_wr_valid;
  logic                 ami_wr_ready;
  logic [AW-1:0]        ami_wr_addr;
  logic [DW-1:0]        ami_wr_data;
  logic                 ami_wr_resp;
  logic                 busy;
  logic                 done;
  logic                 resp_err;

  dnn2ami_wr_sequencer #(
    .NUM_PU(NUM_PU), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
    .BEAT_BYTES(64), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .macro_valid(macro_valid), .macro_ready(macro_ready),
    .macro_addr(macro_addr), .macro_size(macro_size),
    .outbuf_valid(outbuf_valid), .outbuf_data(outbuf_data), .outbuf_pop(outbuf_pop),
    .ami_wr_valid(ami_wr_valid), .ami_wr_ready(ami_wr_ready),
    .ami_wr_addr(ami_wr_addr), .ami_wr_data(ami_wr_data), .ami_wr_resp(ami_wr_resp),
    .busy(busy), .done(done), .resp_err(resp_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            pu;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] buf0[$], buf1[$], exq0[$], exq1[$];
  int            ack_due[$];

  int  n_checks = 0, n_fail = 0, cyc = 0, seq = 0;
  int  ack_lat = 2, stall_from = -1, stall_to = -1;
  bit  ack_hold = 0, ready_low = 0, armed = 0, mv_clear = 0, err_m = 0;
  int  out_m = 0, max_out = 0, n_issue = 0, n_ack = 0, acks_at_done = 0;
  int  done_cnt = 0, done_cyc = -1, accept_cyc = -1, first_issue = -1;
  int  stall_cnt = 0, valid_cnt = 0, pop0_cnt = 0, pop1_cnt = 0;
  bit  prev_stall = 0, s_ready = 0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int pu, input int n);
    logic [31:0] w;
    w = 32'hC0DE_0000 ^ 32'(pu * 4096 + n);
    return {16{w}};
  endfunction

  task automatic drive_bufs();
    outbuf_valid = {buf1.size() != 0, buf0.size() != 0};
    outbuf_data[DW-1:0]    = (buf0.size() != 0) ? buf0[0] : '0;
    outbuf_data[2*DW-1:DW] = (buf1.size() != 0) ? buf1[0] : '0;
  endtask

  task automatic fill(input int pu, input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = mk_data(pu, seq);
      seq++;
      if (pu == 0) begin buf0.push_back(d); exq0.push_back(d); end
      else         begin buf1.push_back(d); exq1.push_back(d); end
    end
    drive_bufs();
  endtask

  // Observe one cycle at the falling edge and update the reference model.
  task automatic sample();
    exp_t e;
    logic [1:0] ep;
    s_ready = macro_ready;
    if (armed && !rst) begin
      check_eq("resp_err", DW'(resp_err), DW'(err_m));
      if (out_m >= MAXO) check_eq("credit_cap_valid", DW'(ami_wr_valid), '0);
      if (prev_stall) begin
        check_eq("bp_valid_held", DW'(ami_wr_valid), DW'(1));
        check_eq("bp_addr_held", DW'(ami_wr_addr), DW'(prev_addr));
        check_eq("bp_data_held", ami_wr_data, prev_data);
      end
      if (ami_wr_valid) valid_cnt++;
      if (ami_wr_valid && !ami_wr_ready) stall_cnt++;
      if (ami_wr_resp) begin
        n_ack++;
        if (out_m > 0) out_m--; else err_m = 1'b1;
      end
      if (ami_wr_valid && ami_wr_ready) begin
        check_eq("sb_nonempty", DW'(sb.size() != 0), DW'(1));
        if (sb.size() != 0) begin
          e  = sb.pop_front();
          ep = 2'b01 << e.pu;
          check_eq("issue_addr", DW'(ami_wr_addr), DW'(e.addr));
          check_eq("issue_data", ami_wr_data, e.data);
          check_eq("pop_onehot", DW'(outbuf_pop), DW'(ep));
        end
        n_issue++;
        out_m++;
        ack_due.push_back(cyc + ack_lat);
        if (first_issue < 0) first_issue = cyc;
      end else begin
        check_eq("pop_idle", DW'(outbuf_pop), '0);
      end
      if (outbuf_pop[0] && buf0.size() != 0) begin void'(buf0.pop_front()); pop0_cnt++; end
      if (outbuf_pop[1] && buf1.size() != 0) begin void'(buf1.pop_front()); pop1_cnt++; end
      if (out_m > max_out) max_out = out_m;
      if (done) begin done_cnt++; done_cyc = cyc; acks_at_done = n_ack; end
      if (macro_valid && macro_ready) begin accept_cyc = cyc; mv_clear = 1'b1; end
      prev_stall = ami_wr_valid && !ami_wr_ready;
      prev_addr  = ami_wr_addr;
      prev_data  = ami_wr_data;
    end
    if (rst) begin
      out_m = 0; err_m = 1'b0; prev_stall = 1'b0;
      sb.delete();
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
    if (mv_clear) begin macro_valid = 1'b0; mv_clear = 1'b0; end
    drive_bufs();
    ami_wr_ready = !(ready_low || (cyc >= stall_from && cyc <= stall_to));
    if (!ack_hold && ack_due.size() != 0 && ack_due[0] <= cyc) begin
      ami_wr_resp = 1'b1;
      void'(ack_due.pop_front());
    end else begin
      ami_wr_resp = 1'b0;
    end
  endtask

  task automatic do_macro(input logic [AW-1:0] addr, input int size);
    exp_t e;
    for (int k = 0; k < size; k++) begin
      e.pu   = k % NUM_PU;
      e.addr = addr + AW'(k * 64);
      e.data = (e.pu == 0) ? exq0.pop_front() : exq1.pop_front();
      sb.push_back(e);
    end
    n_issue = 0; n_ack = 0; done_cnt = 0; done_cyc = -1; accept_cyc = -1;
    first_issue = -1; stall_cnt = 0; valid_cnt = 0; pop0_cnt = 0; pop1_cnt = 0;
    max_out = 0; acks_at_done = 0;
    macro_addr  = addr;
    macro_size  = SW'(size);
    macro_valid = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int i = 0;
    while (done_cnt == 0 && i < bound) begin
      step();
      i++;
    end
    check_eq({tag, "_done_seen"}, DW'(done_cnt), DW'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_macro_ready"}, DW'(macro_ready), DW'(1));
    check_eq({tag, "_busy"}, DW'(busy), '0);
    check_eq({tag, "_valid"}, DW'(ami_wr_valid), '0);
    check_eq({tag, "_pop"}, DW'(outbuf_pop), '0);
    check_eq({tag, "_done"}, DW'(done), '0);
    check_eq({tag, "_resp_err"}, DW'(resp_err), '0);
  endtask

  initial begin
    rst = 1'b1; macro_valid = 1'b0; macro_addr = '0; macro_size = '0;
    outbuf_valid = '0; outbuf_data = '0; ami_wr_ready = 1'b1; ami_wr_resp = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    check_reset_outputs("reset");
    armed = 1'b1;

    // Single beat, ack three cycles after the issue.
    fill(0, 1);
    ack_lat = 3;
    do_macro(64'h1000, 1);
    wait_done("single", 30);
    check_eq("single_first_issue", DW'(first_issue), DW'(accept_cyc + 1));
    check_eq("single_done_lat", DW'(done_cyc - first_issue), DW'(4));
    check_eq("single_pop0", DW'(pop0_cnt), DW'(1));
    check_eq("single_pop1", DW'(pop1_cnt), '0);
    step();
    check_eq("single_done_once", DW'(done_cnt), DW'(1));
    check_eq("single_ready_after", DW'(s_ready), DW'(1));

    // Five beats interleaved across both PUs.
    fill(0, 3); fill(1, 2);
    ack_lat = 2;
    do_macro(64'h1000, 5);
    wait_done("ilv", 40);
    check_eq("ilv_done_cyc", DW'(done_cyc), DW'(accept_cyc + 5 + 2 + 1));
    check_eq("ilv_pop0", DW'(pop0_cnt), DW'(3));
    check_eq("ilv_pop1", DW'(pop1_cnt), DW'(2));
    check_eq("ilv_sb_drained", DW'(sb.size()), '0);
    step();

    // Backpressure: ready low for four cycles mid-stream.
    fill(0, 2); fill(1, 2);
    do_macro(64'h5000, 4);
    stall_from = cyc + 2;
    stall_to   = cyc + 5;
    wait_done("bp", 40);
    check_eq("bp_stall_cycles", DW'(stall_cnt), DW'(4));
    check_eq("bp_issues", DW'(n_issue), DW'(4));
    stall_from = -1; stall_to = -1;
    step();

    // Credit cap: acks withheld until the sequencer stalls at eight.
    fill(0, 6); fill(1, 6);
    ack_hold = 1'b1; ack_lat = 1;
    do_macro(64'h3000, 12);
    repeat (14) step();
    check_eq("cap_issues", DW'(n_issue), DW'(8));
    check_eq("cap_max_out", DW'(max_out), DW'(MAXO));
    check_eq("cap_no_done", DW'(done_cnt), '0);
    ack_hold = 1'b0;
    wait_done("cap", 60);
    check_eq("cap_acks_at_done", DW'(acks_at_done), DW'(12));
    check_eq("cap_total_issues", DW'(n_issue), DW'(12));
    step();

    // Zero-length request.
    do_macro(64'h2000, 0);
    wait_done("zero", 10);
    check_eq("zero_done_cyc", DW'(done_cyc), DW'(accept_cyc + 1));
    check_eq("zero_ready_in_done", DW'(s_ready), '0);
    step();
    check_eq("zero_ready_back", DW'(s_ready), DW'(1));
    check_eq("zero_no_valid", DW'(valid_cnt), '0);
    check_eq("zero_no_pop", DW'(pop0_cnt + pop1_cnt), '0);

    // Reset mid-issue with three writes outstanding, then stray acks.
    fill(0, 4); fill(1, 4);
    ack_hold = 1'b1; ack_lat = 1;
    do_macro(64'h4000, 8);
    for (int i = 0; i < 20 && n_issue < 3; i++) step();
    check_eq("rst_pre_issues", DW'(n_issue), DW'(3));
    ready_low = 1'b1; ami_wr_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; ready_low = 1'b0;
    buf0.delete(); buf1.delete(); exq0.delete(); exq1.delete();
    drive_bufs();
    check_reset_outputs("midrst");
    ack_hold = 1'b0;
    repeat (6) step();
    check_eq("err_acks_seen", DW'(n_ack), DW'(3));
    check_eq("err_sticky", DW'(resp_err), DW'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("err_cleared", DW'(resp_err), '0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dnn2ami_wr_sequencer.md
Name: dnn2ami_wr_sequencer

Overview:
Downstream stage of the DNN2AMI write path. Takes one macro write request at a time (base address, length in beats) and fractures it into single-beat AMI write requests. Beat data is popped from the per-PU output buffers, interleaved round-robin. Tracks outstanding AMI write responses and pulses done once every beat of the macro request has been acknowledged.

Parameters:
NUM_PU, 2, number of PU output buffers interleaved per macro request
DATA_WIDTH, 512, bits per beat / per PU buffer entry
ADDR_WIDTH, 64, AMI byte-address width
SIZE_WIDTH, 10, width of the macro length field (in beats)
BEAT_BYTES, 64, address increment per beat
MAX_OUTSTANDING, 8, cap on AMI writes issued but not yet acknowledged

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
macro_valid  in  1  macro write request present
macro_ready  out  1  sequencer can accept a macro request
macro_addr  in  ADDR_WIDTH  base byte address
macro_size  in  SIZE_WIDTH  number of beats
outbuf_valid  in  NUM_PU  per-PU buffer not empty
outbuf_data  in  NUM_PU*DATA_WIDTH  per-PU show-ahead head entry; PU i at bits [i*DATA_WIDTH +: DATA_WIDTH]
outbuf_pop  out  NUM_PU  one-hot dequeue strobe
ami_wr_valid  out  1  AMI write request valid
ami_wr_ready  in  1  AMI accepts request
ami_wr_addr  out  ADDR_WIDTH  beat address
ami_wr_data  out  DATA_WIDTH  beat data
ami_wr_resp  in  1  one write acknowledged (single-cycle pulse)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at macro completion
resp_err  out  1  sticky: response received with zero outstanding

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; beats_left=0; outstanding=0; pu_sel=0; cur_addr=0.
  - done=0, resp_err=0, outbuf_pop=0, ami_wr_valid=0; macro_ready=1 from the first cycle after reset.
  - Reset mid-operation abandons the macro request. In-flight acks still arriving after reset hit outstanding=0 and set resp_err; this is the intended, documented behaviour.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - macro_ready=1. Handshake is macro_valid&macro_ready.
  - On handshake: latch cur_addr=macro_addr, beats_left=macro_size, pu_sel=0.
  - Next state is ISSUE if macro_size!=0, else DRAIN. A zero-length request therefore produces no AMI traffic.
- ISSUE:
  - ami_wr_valid = outbuf_valid[pu_sel] && outstanding<MAX_OUTSTANDING (combinational).
  - ami_wr_addr=cur_addr; ami_wr_data=outbuf_data slice pu_sel.
  - Once asserted, valid holds until handshake, since neither term can fall without a pop.
- Issue handshake (ami_wr_valid&&ami_wr_ready):
  - outbuf_pop[pu_sel]=1 in the same cycle.
  - cur_addr+=BEAT_BYTES; beats_left-=1.
  - pu_sel = (pu_sel==NUM_PU-1) ? 0 : pu_sel+1.
  - If beats_left was 1, next state is DRAIN.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. No 4 KB boundary splitting.
- outstanding counter:
  - +1 on issue handshake, -1 on ami_wr_resp; both in the same cycle leaves it unchanged.
  - Width is clog2(MAX_OUTSTANDING+1).
  - ami_wr_resp with outstanding==0 sets resp_err; the counter is not decremented.
- DRAIN: when outstanding==0 (a response decrementing 1->0 counts the following cycle), assert done for one cycle and go to IDLE. macro_ready rises the cycle after done.
- Latency:
  - Macro accepted at cycle T gives first ami_wr_valid at T+1, given buffer data and credit.
  - A size-0 request accepted at T gives done at T+1.
  - Best case for N beats with ack latency L: done at T+N+L+1.
- Throughput: one beat per cycle when the AMI is ready, the buffer is non-empty and credit is available.
- Responses are honoured in every state, including IDLE (error path).
- outbuf_pop never asserts outside an issue handshake and is always at most one-hot.

Decomposition:
- Shared package dnn2ami_pkg:
  - state enum (IDLE/ISSUE/DRAIN);
  - BEAT_BYTES default;
  - AMI request struct (addr, data).
- One natural sub-module: dnn2ami_credit_counter, the outstanding up/down counter with limit compare and the underflow error flag.
- The FSM, address generator and PU round-robin stay in the top module.

Test Plan:
- Single beat: macro_addr=0x1000, size=1, PU0 valid; AMI ready; ack 3 cycles later.
  -> one request at addr 0x1000 with PU0 data; pop[0] pulses once; done 4 cycles after the issue.
- Interleave: size=5, NUM_PU=2, both buffers pre-filled.
  -> addrs 0x1000,0x1040,0x1080,0x10C0,0x1100; PU order 0,1,0,1,0; pop[0]×3, pop[1]×2.
- Backpressure: ami_wr_ready low for 4 cycles mid-stream.
  -> valid, addr and data held stable; no pop until ready.
- Credit cap: MAX_OUTSTANDING=8, size=12, acks withheld.
  -> exactly 8 issues, then valid=0; each ack releases one issue; done only after the 12th ack.
- Zero length: size=0.
  -> no ami_wr_valid, no pop; done at T+1; macro_ready back at T+2.
- Reset and error: rst asserted mid-ISSUE with 3 outstanding, then 3 acks.
  -> all outputs at reset values; resp_err=1 after the first ack and stays 1 until the next rst.
